encoder_32to5_seq: RTL
======================

# encoder_32to5_seq

Sequential 32-to-5 encoder. It accepts a 32-bit request vector over a valid/ready handshake and emits the 5-bit index of every set bit, lowest index first, one index per output handshake. It is the inverse companion of the 5-to-32 register-select decoding path. It turns multi-bit select or pending masks back into binary register indices for the downstream register-file and adder control.

## Interface
Parameters: none (width fixed at 32 in, 5 out).

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_vec is offered this cycle
- in_ready  output  1  block can accept a vector this cycle
- in_vec  input  32  request vector; bit k set = index k pending
- flush  input  1  synchronous abort of the vector in progress
- out_valid  output  1  out_idx is valid
- out_ready  input  1  consumer accepts out_idx this cycle
- out_idx  output  5  binary index of lowest pending bit
- out_last  output  1  out_idx is the final index of the current vector
- busy  output  1  a vector is being emitted (state EMIT)

## Operation
- State register: IDLE, EMIT. Pending register pend[31:0].
- IDLE behaviour:
  - in_ready=1, out_valid=0, busy=0.
  - An input handshake is in_valid && in_ready.
  - Handshake with in_vec != 0: pend <= in_vec, next state EMIT.
  - Handshake with in_vec == 0: the vector is consumed and dropped. No output. State stays IDLE.
- EMIT behaviour:
  - in_ready=0, out_valid=1, busy=1.
  - out_idx = position of the lowest set bit of pend. This is a combinational priority encode of the registered pend.
  - out_last=1 iff exactly one bit of pend is set.
- An output handshake is out_valid && out_ready. On each output handshake, bit out_idx of pend is cleared.
- If out_last=1 at the output handshake, pend becomes 0 and the next state is IDLE.
- Stall: while out_ready=0, out_idx and out_last hold stable and pend is unchanged.
- flush=1 on any clock edge: pend <= 0, state <= IDLE.
  - flush overrides a simultaneous input or output handshake.
  - An index presented in the flush cycle counts as not delivered.
  - in_ready is still 1 in IDLE during flush, but a vector offered in that cycle is discarded.
- Number of output handshakes per vector equals popcount(in_vec), from 1 to 32. Indices are strictly increasing.
- out_idx=0 and out_last=0 whenever out_valid=0.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, pend=0.
  - in_ready=1, out_valid=0, out_idx=0, out_last=0, busy=0.
  - Outputs take these values immediately, without waiting for clk.
- Reset released mid-EMIT: the pending vector is lost, with no partial output afterwards.
- Latency:
  - A vector accepted at edge N gives out_valid=1 in the cycle after edge N.
  - With out_ready held high, index i of a vector appears in cycle N+1+i.
  - out_last is asserted in cycle N+popcount.
- After the out_last handshake at edge M, in_ready=1 in the cycle after M. So at best there is one idle/accept cycle between vectors. Input and output are never accepted in the same cycle.
- Throughput: with no stalls, a vector of popcount P occupies 1+P cycles, including the accept cycle.
- Index 31 and index 0 boundaries are both encoded normally. No wrap-around: the scan never revisits lower bits within a vector.

## Test plan
- Reset check: assert rst_n=0 mid-EMIT with in_vec=32'hFFFF_FFFF loaded -> immediately out_valid=0, busy=0, in_ready=1. After release, no stray index is emitted.
- Sparse vector: in_vec=32'h8000_0011, out_ready=1 -> out_idx sequence 0, 4, 31 on consecutive cycles. out_last only on 31. in_ready=1 on the following cycle.
- Backpressure: in_vec=32'h0000_0006, out_ready low for 3 cycles, then high -> out_idx=1 held stable with out_last=0 for all stall cycles. Then 1, 2 are delivered with out_last on 2.
- Zero and full vectors:
  - in_vec=0 -> accepted, no out_valid, stays IDLE.
  - in_vec=32'hFFFF_FFFF -> 32 handshakes with indices 0..31; out_last only at index 31.
- Flush: in_vec=32'h0000_00F0, flush during the out_idx=5 handshake cycle -> next cycle IDLE and out_valid=0. Indices 6 and 7 never appear.
- Back-to-back: 32'h1 then 32'h2 held on in_valid -> out_idx 0 (last), one accept cycle, then out_idx 1 (last). in_ready is never high while out_valid=1.

Source files
------------

// File: rtl/encoder_32to5_seq.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_32to5_seq
//  Description : Sequential 32-to-5 encoder. Accepts a 32-bit request vector
//                over valid/ready and emits the binary index of every set
//                bit, lowest index first, one index per output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_32to5_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_vec,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pend;

    logic [4:0]  w_low_idx;
    logic        w_one_left;
    logic        w_in_hs;
    logic        w_out_hs;

    // Priority encode the lowest set bit of the pending mask; scanning from
    // the top down lets the lowest set bit win the final assignment.
    always_comb begin
        w_low_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_low_idx = 5'(i);
            end
        end
    end

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign w_one_left = (r_pend != 32'd0) && ((r_pend & (r_pend - 32'd1)) == 32'd0);

    // Handshake strobes and outputs decoded straight from the state register,
    // so index and last are forced to zero whenever nothing is offered.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == EMIT);
    assign busy      = (r_state == EMIT);
    assign out_idx   = out_valid ? w_low_idx : 5'd0;
    assign out_last  = out_valid & w_one_left;
    assign w_in_hs   = in_valid & in_ready;
    assign w_out_hs  = out_valid & out_ready;

    // State and pending-mask update; flush dominates both handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= 32'd0;
        end else if (flush) begin
            r_state <= IDLE;
            r_pend  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    // An all-zero vector is consumed without producing output.
                    if (w_in_hs && (in_vec != 32'd0)) begin
                        r_pend  <= in_vec;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_out_hs) begin
                        if (w_one_left) begin
                            r_pend  <= 32'd0;
                            r_state <= IDLE;
                        end else begin
                            // Drop the lowest set bit, which is the index just delivered.
                            r_pend <= r_pend & (r_pend - 32'd1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pend  <= 32'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
